// File: rtl/probe_pkg.sv
// probe_pkg: shared definitions for the probe capture stage.
//   - command opcodes carried in CMD[18:16]
//   - frame header flag bit positions
//   - capture mode and serializer state enumerations
//   - header word layout: {probe number[15:0], word count[7:0], flags[7:0]}
package probe_pkg;

  localparam logic [2:0] OP_OFF    = 3'd0;
  localparam logic [2:0] OP_ALL    = 3'd1;
  localparam logic [2:0] OP_CHANGE = 3'd2;
  localparam logic [2:0] OP_FORCE  = 3'd3;

  localparam int FLAG_OVERRUN = 0;
  localparam int FLAG_FORCED  = 1;
  localparam int FLAG_CHANGE  = 2;

  typedef enum logic [1:0] {
    MODE_OFF,
    MODE_ALL,
    MODE_CHANGE
  } mode_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR,
    S_TS,
    S_DATA
  } ser_state_t;

  function automatic logic [31:0] make_header(input logic [15:0] probe_num,
                                              input logic [7:0]  nwords,
                                              input logic [7:0]  flags);
    return {probe_num, nwords, flags};
  endfunction

endpackage

// File: rtl/probe_capture_if.sv
// probe_capture_if: upstream debug channel between the probe stage and the
// probe hook.
//   DATAUP    : 32-bit frame word
//   DATAVALID : DATAUP holds a valid word
//   DELAY     : stall request, a sample is being lost this cycle
//   ACK       : consumer accepts the current DATAUP word
// master = probe stage, slave = hook / consumer.
interface probe_capture_if;
  logic [31:0] DATAUP;
  logic        DATAVALID;
  logic        DELAY;
  logic        ACK;

  modport master (output DATAUP, output DATAVALID, output DELAY, input ACK);
  modport slave  (input DATAUP, input DATAVALID, input DELAY, output ACK);
endinterface

// File: rtl/probe_frame_ser.sv
// probe_frame_ser: frame register, serializer FSM and output word mux.
// Takes the holding buffer content when idle (or right after the last data
// word of the previous frame) and presents header, timestamp and NWORDS data
// words one at a time, each held until ACK.
//   UCLK, URST          : clock, synchronous active-high reset
//   hold_full           : holding buffer has an entry
//   hold_data/ts/flags  : holding buffer content (flags already include overrun)
//   take                : buffer content moves to the frame register this cycle
//   ack                 : consumer accepts current word
//   dataup, datavalid   : current word and its valid
module probe_frame_ser
  import probe_pkg::*;
#(
  parameter logic [15:0] PROBE_NUM = 16'h0000,
  parameter int          WIDTH     = 64,
  parameter int          NWORDS    = (WIDTH + 31) / 32
) (
  input  logic             UCLK,
  input  logic             URST,
  input  logic             hold_full,
  input  logic [WIDTH-1:0] hold_data,
  input  logic [31:0]      hold_ts,
  input  logic [7:0]       hold_flags,
  output logic             take,
  input  logic             ack,
  output logic [31:0]      dataup,
  output logic             datavalid
);

  localparam int PAD_W = NWORDS * 32;
  localparam int IDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

  ser_state_t       state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic [31:0]      frm_hdr;
  logic [31:0]      frm_ts;
  logic [31:0]      frm_words [NWORDS];
  logic [PAD_W-1:0] hold_pad;
  logic             last_word;

  // Zero-extension pads the top data word.
  assign hold_pad  = PAD_W'(hold_data);
  assign last_word = (idx == LAST_IDX);

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    datavalid = 1'b0;
    dataup    = '0;
    case (state)
      S_IDLE: begin
        if (hold_full) begin
          take      = 1'b1;
          state_nxt = S_HDR;
        end
      end
      S_HDR: begin
        datavalid = 1'b1;
        dataup    = frm_hdr;
        if (ack) state_nxt = S_TS;
      end
      S_TS: begin
        datavalid = 1'b1;
        dataup    = frm_ts;
        if (ack) state_nxt = S_DATA;
      end
      S_DATA: begin
        datavalid = 1'b1;
        dataup    = frm_words[idx];
        if (ack && last_word) begin
          // Chain straight into the next frame when one is waiting.
          if (hold_full) begin
            take      = 1'b1;
            state_nxt = S_HDR;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge UCLK) begin
    if (URST) begin
      state   <= S_IDLE;
      idx     <= '0;
      frm_hdr <= '0;
      frm_ts  <= '0;
      for (int w = 0; w < NWORDS; w++) frm_words[w] <= '0;
    end else begin
      state <= state_nxt;
      if (take) begin
        frm_hdr <= make_header(PROBE_NUM, 8'(NWORDS), hold_flags);
        frm_ts  <= hold_ts;
        for (int w = 0; w < NWORDS; w++) frm_words[w] <= hold_pad[w*32 +: 32];
        idx     <= '0;
      end else if (state == S_DATA && ack && !last_word) begin
        idx <= idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/probe_capture.sv
// probe_capture: active probe stage driving the probe-hook debug channel.
// Samples PROBE_DATA according to the commanded mode, timestamps it with the
// CTIMER-driven cycle counter, stages it in a one-entry holding buffer and
// hands it to probe_frame_ser for serialization under ACK flow control.
//   UCLK, URST   : clock, synchronous active-high reset
//   PROBE_DATA   : probed value (WIDTH bits), PROBE_VALID qualifies it
//   CTIMER       : emulation cycle tick, advances the timestamp
//   CMDEN, CMD   : command strobe, CMD = {opcode[2:0], probe number[15:0]}
//   up           : DATAUP/DATAVALID/DELAY out, ACK in
module probe_capture
  import probe_pkg::*;
#(
  parameter logic [15:0] PROBE_NUM = 16'h0000,
  parameter int          WIDTH     = 64,
  parameter int          NWORDS    = (WIDTH + 31) / 32
) (
  input  logic             UCLK,
  input  logic             URST,
  input  logic [WIDTH-1:0] PROBE_DATA,
  input  logic             PROBE_VALID,
  input  logic             CTIMER,
  input  logic             CMDEN,
  input  logic [18:0]      CMD,
  probe_capture_if.master  up
);

  mode_t            mode;
  logic [31:0]      ts;
  logic [WIDTH-1:0] last_val;
  logic             last_vld;
  logic             hold_full;
  logic [WIDTH-1:0] hold_data;
  logic [31:0]      hold_ts;
  logic [7:0]       hold_flags;
  logic             overrun;

  logic             cmd_hit;
  logic [2:0]       op;
  logic             force_cap;
  logic             norm_cap;
  logic             capture;
  logic             take;
  logic             load;
  logic             drop;
  logic [7:0]       cap_flags;
  logic [7:0]       ser_flags;

  assign cmd_hit   = CMDEN && (CMD[15:0] == PROBE_NUM);
  assign op        = CMD[18:16];
  assign force_cap = cmd_hit && (op == OP_FORCE);

  // Mode changes land at the clock edge, so a sample in the command cycle
  // is judged under the old mode.
  always_comb begin
    norm_cap = 1'b0;
    if (PROBE_VALID) begin
      case (mode)
        MODE_ALL:    norm_cap = 1'b1;
        MODE_CHANGE: norm_cap = !last_vld || (PROBE_DATA != last_val);
        default:     norm_cap = 1'b0;
      endcase
    end
  end

  assign capture = force_cap || norm_cap;
  // A buffer being drained this cycle counts as free.
  assign load    = capture && (!hold_full || take);
  assign drop    = capture && hold_full && !take;
  assign up.DELAY = drop;

  always_comb begin
    cap_flags               = '0;
    cap_flags[FLAG_FORCED]  = force_cap;
    cap_flags[FLAG_CHANGE]  = (mode == MODE_CHANGE);
    ser_flags               = hold_flags;
    ser_flags[FLAG_OVERRUN] = overrun;
  end

  always_ff @(posedge UCLK) begin
    if (URST) begin
      mode       <= MODE_OFF;
      ts         <= '0;
      last_val   <= '0;
      last_vld   <= 1'b0;
      hold_full  <= 1'b0;
      hold_data  <= '0;
      hold_ts    <= '0;
      hold_flags <= '0;
      overrun    <= 1'b0;
    end else begin
      if (CTIMER) ts <= ts + 32'd1;

      if (cmd_hit) begin
        case (op)
          OP_OFF:    mode <= MODE_OFF;
          OP_ALL:    mode <= MODE_ALL;
          OP_CHANGE: mode <= MODE_CHANGE;
          default:   mode <= mode;
        endcase
      end

      // Entering CHANGE forgets the reference so the next sample is taken.
      if (cmd_hit && op == OP_CHANGE) last_vld <= 1'b0;
      else if (load)                  last_vld <= 1'b1;
      if (load) last_val <= PROBE_DATA;

      if (load) begin
        hold_full  <= 1'b1;
        hold_data  <= PROBE_DATA;
        hold_ts    <= ts;
        hold_flags <= cap_flags;
      end else if (take || (cmd_hit && op == OP_OFF)) begin
        hold_full  <= 1'b0;
      end

      // Overrun rides on the header of the entry handed over next.
      if (drop)      overrun <= 1'b1;
      else if (take) overrun <= 1'b0;
    end
  end

  probe_frame_ser #(
    .PROBE_NUM (PROBE_NUM),
    .WIDTH     (WIDTH),
    .NWORDS    (NWORDS)
  ) u_ser (
    .UCLK       (UCLK),
    .URST       (URST),
    .hold_full  (hold_full),
    .hold_data  (hold_data),
    .hold_ts    (hold_ts),
    .hold_flags (ser_flags),
    .take       (take),
    .ack        (up.ACK),
    .dataup     (up.DATAUP),
    .datavalid  (up.DATAVALID)
  );

endmodule

// File: tb/tb_probe_capture.sv
module tb_probe_capture;
  localparam logic [15:0] PN = 16'h0005;
  localparam int          W  = 40;
  localparam int          NW = (W + 31) / 32;

  logic         UCLK = 1'b0;
  logic         URST = 1'b0;
  logic [W-1:0] pdata = '0;
  logic         pvalid = 1'b0;
  logic         ctimer = 1'b0;
  logic         cmden = 1'b0;
  logic [18:0]  cmd = '0;

  probe_capture_if up();

  probe_capture #(.PROBE_NUM(PN), .WIDTH(W)) dut (
    .UCLK        (UCLK),
    .URST        (URST),
    .PROBE_DATA  (pdata),
    .PROBE_VALID (pvalid),
    .CTIMER      (ctimer),
    .CMDEN       (cmden),
    .CMD         (cmd),
    .up          (up)
  );

  always #5 UCLK = ~UCLK;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] got[$];
  logic [31:0] exp[$];
  int          delay_cnt = 0;

  // Accepted words and stall cycles, observed mid-cycle.
  always @(negedge UCLK) begin
    if (up.DATAVALID === 1'b1 && up.ACK === 1'b1) got.push_back(up.DATAUP);
    if (up.DELAY === 1'b1) delay_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge UCLK);
    #1;
  endtask

  task automatic idle_inputs();
    pvalid = 1'b0;
    cmden  = 1'b0;
    cmd    = '0;
    ctimer = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    up.ACK = 1'b1;
    URST   = 1'b1;
    step();
    step();
    URST   = 1'b0;
  endtask

  task automatic send_cmd(input logic [2:0] opc, input logic [15:0] pnum);
    cmden = 1'b1;
    cmd   = {opc, pnum};
    step();
    cmden = 1'b0;
    cmd   = '0;
  endtask

  function automatic logic [W-1:0] rnd_data();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[W-1:0];
  endfunction

  // Expected frame built directly from the frame format description.
  function automatic void model_frame(input logic [7:0] flags, input logic [31:0] t,
                                      input logic [W-1:0] d);
    logic [NW*32-1:0] pad;
    pad = '0;
    pad[W-1:0] = d;
    exp.push_back({PN, 8'(NW), flags});
    exp.push_back(t);
    for (int i = 0; i < NW; i++) exp.push_back(pad[i*32 +: 32]);
  endfunction

  task automatic test_reset();
    URST = 1'b1;
    idle_inputs();
    up.ACK = 1'b1;
    step();
    step();
    @(negedge UCLK);
    checks++;
    if (up.DATAVALID !== 1'b0) begin errors++; $display("FAIL reset_datavalid got %b want 0", up.DATAVALID); end
    checks++;
    if (up.DATAUP !== 32'h0) begin errors++; $display("FAIL reset_dataup got %h want 0", up.DATAUP); end
    checks++;
    if (up.DELAY !== 1'b0) begin errors++; $display("FAIL reset_delay got %b want 0", up.DELAY); end
    step();
    URST = 1'b0;
  endtask

  task automatic test_basic();
    logic [31:0] want [4];
    int n;
    want[0] = 32'h0005_0200; want[1] = 32'h0000_0007;
    want[2] = 32'h3456_789A; want[3] = 32'h0000_0012;
    do_reset();
    send_cmd(3'd1, PN);
    ctimer = 1'b1;
    repeat (7) step();
    ctimer = 1'b0;
    pdata  = 40'h12_3456_789A;
    pvalid = 1'b1;
    step();
    pvalid = 1'b0;
    n = 0;
    @(negedge UCLK);
    while (up.DATAVALID !== 1'b1 && n < 10) begin @(negedge UCLK); n++; end
    checks++;
    if (up.DATAVALID !== 1'b1) begin errors++; $display("FAIL basic_start datavalid got %b want 1", up.DATAVALID); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (up.DATAVALID !== 1'b1 || up.DATAUP !== want[k]) begin
        errors++;
        $display("FAIL basic_word%0d got %h (valid %b) want %h", k, up.DATAUP, up.DATAVALID, want[k]);
      end
      @(negedge UCLK);
    end
    checks++;
    if (up.DATAVALID !== 1'b0) begin errors++; $display("FAIL basic_end datavalid got %b want 0", up.DATAVALID); end
    step();
  endtask

  task automatic test_other_probe();
    int cnt;
    do_reset();
    send_cmd(3'd1, 16'h0006);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      pvalid = (i < 6);
      pdata  = rnd_data();
      @(negedge UCLK);
      if (up.DATAVALID === 1'b1) cnt++;
      step();
    end
    pvalid = 1'b0;
    checks++;
    if (cnt != 0) begin errors++; $display("FAIL other_probe valid_cycles got %0d want 0", cnt); end
  endtask

  task automatic test_overrun();
    logic [W-1:0] d [3];
    int base, dbase;
    do_reset();
    send_cmd(3'd1, PN);
    up.ACK = 1'b0;
    exp.delete();
    dbase = delay_cnt;
    for (int i = 0; i < 3; i++) begin
      d[i]   = rnd_data();
      pdata  = d[i];
      pvalid = 1'b1;
      @(negedge UCLK);
      checks++;
      if (up.DELAY !== 1'(i == 2)) begin
        errors++;
        $display("FAIL overrun_delay_s%0d got %b want %b", i, up.DELAY, 1'(i == 2));
      end
      step();
    end
    pvalid = 1'b0;
    step();
    step();
    @(negedge UCLK);
    checks++;
    if (up.DATAVALID !== 1'b1 || up.DATAUP !== 32'h0005_0200) begin
      errors++;
      $display("FAIL overrun_held got %h (valid %b) want 00050200", up.DATAUP, up.DATAVALID);
    end
    step();
    base = got.size();
    up.ACK = 1'b1;
    repeat (20) step();
    model_frame(8'h00, 32'h0, d[0]);
    model_frame(8'h01, 32'h0, d[1]);
    checks++;
    if (got.size() - base != exp.size()) begin
      errors++;
      $display("FAIL overrun_count got %0d want %0d", got.size() - base, exp.size());
    end
    for (int i = 0; i < exp.size() && base + i < got.size(); i++) begin
      checks++;
      if (got[base+i] !== exp[i]) begin errors++; $display("FAIL overrun_word%0d got %h want %h", i, got[base+i], exp[i]); end
    end
    checks++;
    if (delay_cnt - dbase != 1) begin errors++; $display("FAIL overrun_delay_total got %0d want 1", delay_cnt - dbase); end
  endtask

  task automatic test_change();
    int base, dbase;
    logic [W-1:0] vals [3];
    vals[0] = 40'hAB; vals[1] = 40'hAB; vals[2] = 40'hAC;
    do_reset();
    send_cmd(3'd2, PN);
    exp.delete();
    base  = got.size();
    dbase = delay_cnt;
    for (int i = 0; i < 3; i++) begin
      pdata  = vals[i];
      pvalid = 1'b1;
      step();
    end
    pvalid = 1'b0;
    repeat (20) step();
    model_frame(8'h04, 32'h0, 40'hAB);
    model_frame(8'h04, 32'h0, 40'hAC);
    checks++;
    if (got.size() - base != exp.size()) begin
      errors++;
      $display("FAIL change_count got %0d want %0d", got.size() - base, exp.size());
    end
    for (int i = 0; i < exp.size() && base + i < got.size(); i++) begin
      checks++;
      if (got[base+i] !== exp[i]) begin errors++; $display("FAIL change_word%0d got %h want %h", i, got[base+i], exp[i]); end
    end
    checks++;
    if (delay_cnt - dbase != 0) begin errors++; $display("FAIL change_delay got %0d want 0", delay_cnt - dbase); end
  endtask

  task automatic test_force();
    int base;
    do_reset();
    exp.delete();
    base   = got.size();
    pvalid = 1'b0;
    pdata  = 40'h1;
    cmden  = 1'b1;
    cmd    = {3'd3, PN};
    step();
    cmden  = 1'b0;
    cmd    = '0;
    repeat (15) step();
    model_frame(8'h02, 32'h0, 40'h1);
    checks++;
    if (got.size() - base != exp.size()) begin
      errors++;
      $display("FAIL force_count got %0d want %0d", got.size() - base, exp.size());
    end
    for (int i = 0; i < exp.size() && base + i < got.size(); i++) begin
      checks++;
      if (got[base+i] !== exp[i]) begin errors++; $display("FAIL force_word%0d got %h want %h", i, got[base+i], exp[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int n, base;
    logic [W-1:0] d;
    do_reset();
    send_cmd(3'd1, PN);
    ctimer = 1'b1;
    repeat (3) step();
    ctimer = 1'b0;
    up.ACK = 1'b0;
    pdata  = rnd_data();
    pvalid = 1'b1;
    step();
    pvalid = 1'b0;
    n = 0;
    @(negedge UCLK);
    while (up.DATAVALID !== 1'b1 && n < 10) begin @(negedge UCLK); n++; end
    checks++;
    if (up.DATAUP !== 32'h0005_0200) begin errors++; $display("FAIL midrst_hdr got %h want 00050200", up.DATAUP); end
    up.ACK = 1'b1;
    step();
    up.ACK = 1'b0;
    @(negedge UCLK);
    checks++;
    if (up.DATAVALID !== 1'b1 || up.DATAUP !== 32'h3) begin
      errors++;
      $display("FAIL midrst_ts got %h (valid %b) want 00000003", up.DATAUP, up.DATAVALID);
    end
    step();
    URST   = 1'b1;
    pvalid = 1'b1;
    step();
    URST   = 1'b0;
    @(negedge UCLK);
    checks++;
    if (up.DATAVALID !== 1'b0) begin errors++; $display("FAIL midrst_datavalid got %b want 0", up.DATAVALID); end
    checks++;
    if (up.DELAY !== 1'b0) begin errors++; $display("FAIL midrst_delay got %b want 0", up.DELAY); end
    step();
    up.ACK = 1'b1;
    base = got.size();
    for (int i = 0; i < 10; i++) begin
      pdata = rnd_data();
      step();
    end
    pvalid = 1'b0;
    repeat (8) step();
    checks++;
    if (got.size() != base) begin errors++; $display("FAIL midrst_off_words got %0d want 0", got.size() - base); end
    exp.delete();
    base  = got.size();
    d     = rnd_data();
    pdata = d;
    cmden = 1'b1;
    cmd   = {3'd3, PN};
    step();
    cmden = 1'b0;
    cmd   = '0;
    repeat (15) step();
    model_frame(8'h02, 32'h0, d);
    checks++;
    if (got.size() - base != exp.size()) begin
      errors++;
      $display("FAIL midrst_force_count got %0d want %0d", got.size() - base, exp.size());
    end
    for (int i = 0; i < exp.size() && base + i < got.size(); i++) begin
      checks++;
      if (got[base+i] !== exp[i]) begin errors++; $display("FAIL midrst_force_word%0d got %h want %h", i, got[base+i], exp[i]); end
    end
  endtask

  // Random commands and samples against a mode/last-value/timestamp model.
  // Each capture is followed by idle cycles so frames never contend.
  task automatic test_random();
    int           m, gap, base, dbase;
    logic [W-1:0] last;
    bit           lastv, hit, frc, nrm;
    logic [2:0]   opc;
    logic [31:0]  mts;
    logic [W-1:0] pool [3];
    for (int i = 0; i < 3; i++) pool[i] = rnd_data();
    do_reset();
    exp.delete();
    base  = got.size();
    dbase = delay_cnt;
    m = 0; gap = 0; last = '0; lastv = 1'b0; mts = 32'h0;
    for (int c = 0; c < 400; c++) begin
      cmden  = 1'b0;
      cmd    = '0;
      pvalid = 1'b0;
      ctimer = 1'($urandom % 2);
      if (gap > 0) begin
        gap--;
      end else begin
        if ($urandom % 5 == 0) begin
          cmden = 1'b1;
          cmd   = {3'($urandom % 8), ($urandom % 4 == 0) ? 16'($urandom) : PN};
        end
        pvalid = 1'($urandom % 2);
        pdata  = pool[$urandom % 3];
      end
      hit = cmden && (cmd[15:0] == PN);
      opc = cmd[18:16];
      frc = hit && (opc == 3'd3);
      nrm = pvalid && (m == 1 || (m == 2 && (!lastv || pdata != last)));
      if (frc || nrm) begin
        model_frame({5'b0, 1'(m == 2), frc, 1'b0}, mts, pdata);
        last  = pdata;
        lastv = 1'b1;
        gap   = 5;
      end
      if (hit && opc == 3'd2) lastv = 1'b0;
      if (hit && opc <= 3'd2) m = int'(opc);
      mts = mts + 32'(ctimer);
      step();
    end
    idle_inputs();
    repeat (20) step();
    checks++;
    if (got.size() - base != exp.size()) begin
      errors++;
      $display("FAIL random_count got %0d want %0d", got.size() - base, exp.size());
    end
    for (int i = 0; i < exp.size() && base + i < got.size(); i++) begin
      checks++;
      if (got[base+i] !== exp[i]) begin errors++; $display("FAIL random_word%0d got %h want %h", i, got[base+i], exp[i]); end
    end
    checks++;
    if (delay_cnt - dbase != 0) begin errors++; $display("FAIL random_delay got %0d want 0", delay_cnt - dbase); end
  endtask

  initial begin
    up.ACK = 1'b1;
    test_reset();
    test_basic();
    test_other_probe();
    test_overrun();
    test_change();
    test_force();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
